// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter
//   Round-robin arbiter over 16 requesters with a one-hot decoded grant.
//   FSM: IDLE (arbitrate) -> GRANT (hold) -> GAP (one dead cycle) -> IDLE.
//   The rotating pointer moves to the slot after the last grant holder.
//
// Optional feature (compile-time macro DECODER_RR_ARBITER_TIMEOUT_EN):
//   A watchdog revokes a grant after TIMEOUT_CYCLES GRANT cycles and pulses
//   timeout for one cycle. Without the macro, timeout is tied low.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   req[15:0] in   request lines, bit i = requester i
//   done      in   current holder releases the resource
//   gnt_valid out  grant active
//   gnt_idx   out  binary index of the granted requester
//   gnt[15:0] out  one-hot decode of gnt_idx, zero when no grant
//   timeout   out  one-cycle pulse when the watchdog revokes a grant
module decoder_rr_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  ptr, ptr_nxt;
  logic [3:0]  idx_nxt;
  logic [3:0]  winner;
  logic [3:0]  cand;
  logic        found;
  logic        rel;
  logic        expire;

  // First set request at or above ptr, wrapping 15 -> 0.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // done and a dropped request in the same cycle collapse into one release.
  assign rel = done || !req[gnt_idx];

`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // wd_cnt holds the number of completed GRANT cycles of the current grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == GRANT && state_nxt == GRANT) begin
      wd_cnt <= wd_cnt + 8'd1;
    end else begin
      wd_cnt <= '0;
    end
  end

  assign expire = (state == GRANT) && (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

  // A regular release in the expiry cycle wins; no timeout pulse then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout <= 1'b0;
    end else begin
      timeout <= (state == GRANT) && expire && !rel;
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
        end
      end
      GRANT: begin
        if (rel || expire) begin
          state_nxt = GAP;
          ptr_nxt   = gnt_idx + 4'd1;
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt_idx <= idx_nxt;
    end
  end

  assign gnt_valid = (state == GRANT);

  always_comb begin
    gnt = '0;
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Testbench for decoder_rr_arbiter: directed stimulus, expected grant
// indices pushed into a queue, a monitor pops one per new grant.
module tb_decoder_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt;
  logic        timeout;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  int unsigned exp_q[$];

  decoder_rr_arbiter #(.TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each rising gnt_valid consumes one expected index.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (gnt_valid === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(gnt_idx), 32'hFFFF_FFFF);
      end else begin
        int unsigned e;
        logic [15:0] oh;
        e  = exp_q.pop_front();
        oh = 16'h0001 << e;
        check("gnt_idx", 32'(gnt_idx), e);
        check("gnt_onehot", 32'(gnt), 32'(oh));
      end
    end
    prev_valid = gnt_valid;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Returns at the first negedge where gnt_valid is high.
  task automatic wait_grant(input string name);
    int unsigned k;
    k = 0;
    @(negedge clk);
    while (gnt_valid !== 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    if (gnt_valid !== 1'b1) check({name, "_grant_timeout"}, 32'(gnt_valid), 32'd1);
  endtask

  // Called at a negedge during GRANT: pulse done, then check the GAP cycle.
  task automatic release_done(input string name);
    done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    @(negedge clk);
    check({name, "_gap_valid"}, 32'(gnt_valid), 32'd0);
    check({name, "_gap_gnt"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    int unsigned cnt;
    logic        tout_seen;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);

    // Single requester 4
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(4);
    req = 16'h0010;
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_valid", 32'(gnt_valid), 32'd1);
    release_done("single");
    req = '0;

    // Full rotation with all requests held
    do_reset();
    for (int unsigned i = 0; i < 17; i++) exp_q.push_back(i % 16);
    req = 16'hFFFF;
    for (int unsigned i = 0; i < 17; i++) begin
      wait_grant("rot");
      release_done("rot");
    end
    req = '0;

    // Wrap-around from ptr=14; done and dropped request together
    do_reset();
    exp_q.push_back(13);
    req = 16'h2000;
    wait_grant("wrap13");
    req  = 16'h0003;
    release_done("wrap13");
    exp_q.push_back(0);
    exp_q.push_back(1);
    wait_grant("wrap0");
    release_done("wrap0");
    wait_grant("wrap1");
    release_done("wrap1");
    req = '0;

    // Grant frozen on 7, release by dropping req[7]; ptr=8 wraps to 0
    do_reset();
    exp_q.push_back(7);
    req = 16'h0080;
    wait_grant("hold7");
    req = 16'h0F80;
    repeat (3) @(negedge clk);
    check("frozen_idx", 32'(gnt_idx), 32'd7);
    check("frozen_gnt", 32'(gnt), 32'h0080);
    req = 16'h0000;
    @(negedge clk);
    check("drop_gap_valid", 32'(gnt_valid), 32'd0);
    exp_q.push_back(0);
    req = 16'h0081;
    wait_grant("after7");
    release_done("after7");
    req = '0;

    // Asynchronous reset mid-grant
    do_reset();
    exp_q.push_back(9);
    req = 16'h0200;
    wait_grant("pre_rst9");
    rst = 1'b1;
    #1;
    check("async_valid", 32'(gnt_valid), 32'd0);
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_idx", 32'(gnt_idx), 32'd0);
    exp_q.push_back(9);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_grant("post_rst9");
    release_done("post_rst9");
    req = '0;

    // Watchdog behaviour with done held low
    do_reset();
    exp_q.push_back(5);
    req = 16'h0020;
    wait_grant("wd");
    cnt       = 1;
    tout_seen = 1'b0;
    while (cnt < 30) begin
      @(negedge clk);
      if (timeout === 1'b1) tout_seen = 1'b1;
      if (gnt_valid !== 1'b1) break;
      cnt++;
    end
`ifdef DECODER_RR_ARBITER_TIMEOUT_EN
    check("wd_grant_cycles", cnt, 32'd15);
    check("wd_timeout_pulse", 32'(timeout), 32'd1);
    @(negedge clk);
    check("wd_timeout_clear", 32'(timeout), 32'd0);
    req = '0;
`else
    check("wd_grant_held", 32'(gnt_valid), 32'd1);
    check("wd_no_timeout", 32'(tout_seen), 32'd0);
    release_done("wd");
    req = '0;
`endif

    // Drain the scoreboard
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of cycles a grant is held when the timeout feature is compiled in (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 16 bits: one request line per requester; bit i is requester i.
REQ-005 The block SHALL have port done, input, 1 bit: the current grant holder releases the resource.
REQ-006 The block SHALL have port gnt_valid, output, 1 bit: a grant is active.
REQ-007 The block SHALL have port gnt_idx, output, 4 bits: binary index of the granted requester.
REQ-008 The block SHALL have port gnt, output, 16 bits: one-hot 4-to-16 decode of gnt_idx, qualified by gnt_valid.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, GRANT and GAP.
REQ-011 In IDLE with req != 0, the block SHALL select the first set req bit at or after ptr, searching upward with wrap 15->0, and SHALL enter GRANT with gnt_valid=1 and gnt_idx=winner on the next edge.
REQ-012 Latency SHALL be one cycle: req sampled at edge N gives gnt_valid=1 after edge N+1.
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with gnt_valid=0.
REQ-014 In GRANT, gnt_idx SHALL stay frozen and req changes on other bits SHALL be ignored.
REQ-015 In GRANT, done=1 or req[gnt_idx]=0 SHALL end the grant: go to GAP, gnt_valid=0 after that edge, and ptr=gnt_idx+1 modulo 16 (15 wraps to 0).
REQ-016 If done=1 and req[gnt_idx]=0 occur in the same cycle, the block SHALL treat them as a single release.
REQ-017 GAP SHALL last exactly one cycle with gnt_valid=0 and gnt=0, then go to IDLE; req SHALL be re-arbitrated in IDLE and not in GAP.
REQ-018 gnt SHALL equal 1<<gnt_idx when gnt_valid=1, and 16'h0000 otherwise; it SHALL never have more than one bit set.
REQ-019 done while in IDLE or GAP SHALL be ignored.
REQ-020 With every req bit held at 1, grants SHALL rotate through indices 0,1,...,15,0 with no requester skipped.

Reset
REQ-021 Asserting rst SHALL immediately force the FSM to IDLE, ptr=0, gnt_valid=0, gnt_idx=0, gnt=0, timeout=0 and watchdog count=0, including mid-grant.
REQ-022 After rst deasserts, the first arbitration SHALL happen at the first rising edge where rst=0 and req != 0.

Configuration
REQ-023 With macro DECODER_RR_ARBITER_TIMEOUT_EN defined, a watchdog SHALL count GRANT cycles; if the grant reaches TIMEOUT_CYCLES cycles without release, the block SHALL go to GAP, pulse timeout=1 for one cycle and advance ptr as in REQ-015.
REQ-024 Without DECODER_RR_ARBITER_TIMEOUT_EN, no watchdog logic SHALL exist, timeout SHALL be tied to 0, and a grant SHALL persist until it is released.

Verification
REQ-025 Reset, then req=16'h0010 -> one cycle later gnt_valid=1, gnt_idx=4, gnt=16'h0010; done=1 for one cycle -> one GAP cycle with gnt=0.
REQ-026 req=16'hFFFF held and done pulsed one cycle after each grant -> gnt_idx sequence 0,1,2,...,15,0, each grant followed by one GAP cycle.
REQ-027 Hold ptr=14 with req=16'h0003 -> grant goes to 0, then to 1; checks wrap-around.
REQ-028 Grant held on idx 7, then req[7] drops with done=0 -> release; next grant with req=16'h0081 goes to 0 (ptr=8 wraps).
REQ-029 Assert rst while granted on idx 9 -> gnt, gnt_valid and gnt_idx go to 0 immediately, before the next edge; after release, req=16'h0200 -> idx 9 granted (ptr reset to 0).
REQ-030 With TIMEOUT_EN and TIMEOUT_CYCLES=15, hold done=0 -> gnt_valid drops after 15 GRANT cycles with timeout=1 for one cycle; without the macro -> the grant is held indefinitely and timeout stays 0.
